// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice.
//   - ALU_DATA_W : default operand/result width
//   - ALU_OP_W   : default opcode width
//   - OP_*       : ALU opcode encodings
//   - arb_state_e: arbiter FSM state encodings (ST_IDLE, ST_EXEC, ST_RESP)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_OP_W   = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SHR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU used in the arbiter's execute cycle.
// Ports:
//   op     input  OP_W    operation code (see alu_pkg OP_*)
//   a, b   input  DATA_W  operands
//   result output DATA_W  operation result
//   zero   output 1       result == 0
//   equal  output 1       a == b
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              equal
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh_amt_s;
    logic            sh_oversize_s;
    logic [DATA_W-1:0] result_s;

    // The full B value is compared so any shift of DATA_W or more clears the
    // result; below that bound the low bits are the exact shift distance.
    assign sh_amt_s      = b[SH_W-1:0];
    assign sh_oversize_s = (b >= DATA_W'(DATA_W));

    // Operation decode and evaluation.
    always_comb begin
        result_s = {DATA_W{1'b0}};
        case (op)
            OP_ADD: result_s = a + b;
            OP_SUB: result_s = a - b;
            OP_NOT: result_s = ~a;
            OP_SHL: begin
                if (sh_oversize_s) begin
                    result_s = {DATA_W{1'b0}};
                end else begin
                    result_s = a << sh_amt_s;
                end
            end
            OP_SHR: begin
                if (sh_oversize_s) begin
                    result_s = {DATA_W{1'b0}};
                end else begin
                    result_s = a >> sh_amt_s;
                end
            end
            OP_AND: result_s = a & b;
            OP_OR:  result_s = a | b;
            OP_SLT: result_s = {{(DATA_W-1){1'b0}}, (a < b)};
            default: result_s = {DATA_W{1'b0}};
        endcase
    end

    assign result = result_s;
    assign zero   = (result_s == {DATA_W{1'b0}});
    assign equal  = (a == b);

endmodule : alu_core

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters (0: execute stage, 1: in-memory
// compute controller). Round-robin arbitration in IDLE, one execute cycle
// through alu_core, then a registered response held until accepted.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid[1:0], req_ready[1:0] per-requester handshake (ready is one-hot
//                                   or zero, combinational in IDLE)
//   req_op0/1, req_a0/1, req_b0/1 per-requester opcode and operands
//   rsp_valid, rsp_ready          response handshake
//   rsp_id, rsp_result            issuing requester and ALU result
//   rsp_zero, rsp_equal           result == 0, captured A == captured B
//   grant_cnt0/1                  saturating grant counters (only when the
//                                   ALU_ARB_STATS_EN macro is defined)
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_equal
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    arb_state_e        state_r;
    arb_state_e        next_state_s;
    logic              ptr_r;
    logic              grant_s;
    logic              hs_s;
    logic [1:0]        req_ready_s;

    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              id_r;

    logic [DATA_W-1:0] alu_result_s;
    logic              alu_zero_s;
    logic              alu_equal_s;

    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic [DATA_W-1:0] rsp_result_r;
    logic              rsp_zero_r;
    logic              rsp_equal_r;

    // Round-robin pick: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        grant_s = 1'b0;
        if (req_valid == 2'b11) begin
            grant_s = ptr_r;
        end else if (req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        next_state_s = state_r;
        req_ready_s  = 2'b00;
        hs_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    // Ready is raised only towards the winner, so any valid
                    // winner completes the handshake this cycle.
                    hs_s         = 1'b1;
                    req_ready_s  = grant_s ? 2'b10 : 2'b01;
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture and pointer update on the request handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= {OP_W{1'b0}};
            a_r   <= {DATA_W{1'b0}};
            b_r   <= {DATA_W{1'b0}};
            id_r  <= 1'b0;
            ptr_r <= 1'b0;
        end else if (hs_s) begin
            op_r  <= grant_s ? req_op1 : req_op0;
            a_r   <= grant_s ? req_a1  : req_a0;
            b_r   <= grant_s ? req_b1  : req_b0;
            id_r  <= grant_s;
            ptr_r <= ~grant_s;
        end
    end

    alu_core #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu_core (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .result (alu_result_s),
        .zero   (alu_zero_s),
        .equal  (alu_equal_s)
    );

    // Response registers: loaded at the end of EXEC, held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= {DATA_W{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_equal_r  <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= id_r;
            rsp_result_r <= alu_result_s;
            rsp_zero_r   <= alu_zero_s;
            rsp_equal_r  <= alu_equal_s;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_zero   = rsp_zero_r;
    assign rsp_equal  = rsp_equal_r;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0_r;
    logic [15:0] grant_cnt1_r;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0_r <= 16'h0000;
            grant_cnt1_r <= 16'h0000;
        end else if (hs_s) begin
            if (!grant_s && (grant_cnt0_r != 16'hFFFF)) begin
                grant_cnt0_r <= grant_cnt0_r + 16'h0001;
            end
            if (grant_s && (grant_cnt1_r != 16'hFFFF)) begin
                grant_cnt1_r <= grant_cnt1_r + 16'h0001;
            end
        end
    end

    assign grant_cnt0 = grant_cnt0_r;
    assign grant_cnt1 = grant_cnt1_r;
`endif

endmodule : alu_arbiter
